// File: rtl/cpu4_core.sv
// ---------------------------------------------------------------------------
// cpu4_core
//
// Single-cycle 4-bit accumulator processor core. The program counter
// addresses an external combinational program ROM. The returned instruction
// is decoded, executed and retired in the same clock cycle.
//
// Instruction word: [7:4] opcode, [3:0] immediate.
//   0x0 NOP   no state change except pc
//   0x1 LDI   acc <= immediate
//   0x2 ADD   reg <= acc + reg
//   0x3 SUB   reg <= acc - reg
//   0x4 AND   reg <= acc & reg
//   0x5 XOR   reg <= acc ^ reg
//   0x6-0xE   treated as NOP
//   0xF RST   pc <= 0, no other state change
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous active-high reset, clears pc/acc/reg
//   instr    instruction word fetched from ROM[pc]
//   pc       program counter, used as the ROM address
//   acc_out  accumulator contents
//   reg_out  working register contents
//   alu_out  combinational ALU result (acc op reg)
//   decoded  control word {mux_sel, reg_ce, acc_ce, alu_op[1:0]}
//   restart  high only while the current opcode is RST
// ---------------------------------------------------------------------------
module cpu4_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] reg_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [4:0]        decoded,
    output logic              restart
);

    // Opcode encodings
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_RST = 4'hF;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // Decoder control word, bit order matches the decoded output port
    typedef struct packed {
        logic       mux_sel;
        logic       reg_ce;
        logic       acc_ce;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{mux_sel: 1'b0, reg_ce: 1'b0, acc_ce: 1'b0, alu_op: 2'b00};

    // Opcode to control word. Anything unrecognised (including RST) maps to
    // the idle word so that it can never enable a state write.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (op)
            OP_NOP: c = CTRL_IDLE;
            OP_LDI: c = '{mux_sel: 1'b1, reg_ce: 1'b0, acc_ce: 1'b1, alu_op: ALU_ADD};
            OP_ADD: c = '{mux_sel: 1'b0, reg_ce: 1'b1, acc_ce: 1'b0, alu_op: ALU_ADD};
            OP_SUB: c = '{mux_sel: 1'b0, reg_ce: 1'b1, acc_ce: 1'b0, alu_op: ALU_SUB};
            OP_AND: c = '{mux_sel: 1'b0, reg_ce: 1'b1, acc_ce: 1'b0, alu_op: ALU_AND};
            OP_XOR: c = '{mux_sel: 1'b0, reg_ce: 1'b1, acc_ce: 1'b0, alu_op: ALU_XOR};
            OP_RST: c = CTRL_IDLE;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // ALU datapath. Results wrap modulo 2^DATA_W and carry/borrow are dropped.
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] in1,
        input logic [DATA_W-1:0] in2
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            ALU_ADD: r = in1 + in2;
            ALU_SUB: r = in1 - in2;
            ALU_AND: r = in1 & in2;
            ALU_XOR: r = in1 ^ in2;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Internal signals and state
    logic [3:0]        opcode_s;
    logic [3:0]        imm_raw_s;
    logic [DATA_W-1:0] imm_s;
    ctrl_t             ctrl_s;
    logic              restart_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] acc_d_s;
    logic [ADDR_W-1:0] pc_next_s;

    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] reg_r;

    assign opcode_s  = instr[7:4];
    assign imm_raw_s = instr[3:0];
    assign imm_s     = DATA_W'(imm_raw_s);

    // Instruction decode: control word and restart request
    always_comb begin
        ctrl_s    = CTRL_IDLE;
        restart_s = 1'b0;
        ctrl_s    = decode_op(opcode_s);
        if (opcode_s == OP_RST) begin
            restart_s = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
    end

    // ALU and accumulator input mux
    always_comb begin
        alu_s   = '0;
        acc_d_s = acc_r;
        alu_s   = alu_calc(ctrl_s.alu_op, acc_r, reg_r);
        if (ctrl_s.mux_sel) begin
            acc_d_s = imm_s;
        end else begin
            acc_d_s = acc_r;
        end
    end

    // Next program counter: restart to 0, otherwise increment with natural wrap
    always_comb begin
        pc_next_s = '0;
        if (restart_s) begin
            pc_next_s = '0;
        end else begin
            pc_next_s = pc_r + ADDR_W'(1);
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= '0;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Accumulator register, written only by LDI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (ctrl_s.acc_ce) begin
            acc_r <= acc_d_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Working register, written with the ALU result by ADD/SUB/AND/XOR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_r <= '0;
        end else if (ctrl_s.reg_ce) begin
            reg_r <= alu_s;
        end else begin
            reg_r <= reg_r;
        end
    end

    assign pc      = pc_r;
    assign acc_out = acc_r;
    assign reg_out = reg_r;
    assign alu_out = alu_s;
    assign decoded = ctrl_s;
    assign restart = restart_s;

endmodule

// File: tb/tb_cpu4_core.sv
// ---------------------------------------------------------------------------
// tb_cpu4_core
//
// Directed bench for cpu4_core. A ROM array in the bench feeds instr from
// pc. Expected architectural state after each clock edge is pushed to a
// scoreboard queue before the edge and popped and compared after it.
// ---------------------------------------------------------------------------
module tb_cpu4_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr;
    logic [3:0] pc;
    logic [3:0] acc_out;
    logic [3:0] reg_out;
    logic [3:0] alu_out;
    logic [4:0] decoded;
    logic       restart;

    logic [7:0] rom [16];

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [3:0] pc;
        logic [3:0] acc;
        logic [3:0] rg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign instr = rom[pc];

    cpu4_core #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .instr   (instr),
        .pc      (pc),
        .acc_out (acc_out),
        .reg_out (reg_out),
        .alu_out (alu_out),
        .decoded (decoded),
        .restart (restart)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_after(input string tag, input logic [3:0] p,
                                input logic [3:0] a, input logic [3:0] r);
        exp_t e;
        e.tag = tag;
        e.pc  = p;
        e.acc = a;
        e.rg  = r;
        sb.push_back(e);
    endtask

    // One rising edge, then compare the DUT state with the oldest expectation
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_pc"},  {4'h0, pc},      {4'h0, e.pc});
            chk({e.tag, "_acc"}, {4'h0, acc_out}, {4'h0, e.acc});
            chk({e.tag, "_reg"}, {4'h0, reg_out}, {4'h0, e.rg});
        end
    endtask

    initial begin
        // Program A: load/add, arithmetic chain, then restart at address 6
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h13;
        rom[1] = 8'h20;
        rom[2] = 8'h15;
        rom[3] = 8'h30;
        rom[4] = 8'h50;
        rom[5] = 8'h40;
        rom[6] = 8'hF0;

        // Reset state
        #1;
        chk("rst_pc",  {4'h0, pc},      8'h00);
        chk("rst_acc", {4'h0, acc_out}, 8'h00);
        chk("rst_reg", {4'h0, reg_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // LDI 3, then ADD
        chk("ldi_dec", {3'h0, decoded}, 8'h14);
        expect_after("ldi3", 4'h1, 4'h3, 4'h0);
        tick();
        chk("add_dec", {3'h0, decoded}, 8'h08);
        chk("add_alu", {4'h0, alu_out}, 8'h03);
        expect_after("add", 4'h2, 4'h3, 4'h3);
        tick();

        // Arithmetic chain
        expect_after("ldi5", 4'h3, 4'h5, 4'h3);
        tick();
        chk("sub_dec", {3'h0, decoded}, 8'h09);
        expect_after("sub", 4'h4, 4'h5, 4'h2);
        tick();
        chk("xor_dec", {3'h0, decoded}, 8'h0B);
        expect_after("xor", 4'h5, 4'h5, 4'h7);
        tick();
        chk("and_dec", {3'h0, decoded}, 8'h0A);
        expect_after("and", 4'h6, 4'h5, 4'h5);
        tick();

        // RST at pc=6
        chk("rst_op_restart", {7'h0, restart}, 8'h01);
        chk("rst_op_dec",     {3'h0, decoded}, 8'h00);
        expect_after("restart", 4'h0, 4'h5, 4'h5);
        tick();

        // Program B: modular results, unknown opcodes, wrap at 15
        rom[1]  = 8'h39;
        rom[2]  = 8'h1C;
        rom[3]  = 8'h57;
        rom[4]  = 8'h1F;
        rom[5]  = 8'h2A;
        rom[6]  = 8'h6A;
        rom[7]  = 8'h75;
        rom[8]  = 8'h8F;
        rom[9]  = 8'h91;
        rom[10] = 8'hA3;
        rom[11] = 8'hBC;
        rom[12] = 8'hCD;
        rom[13] = 8'hDE;
        rom[14] = 8'hE0;
        rom[15] = 8'h00;
        chk("restart_low", {7'h0, restart}, 8'h00);

        expect_after("b_ldi3", 4'h1, 4'h3, 4'h5);
        tick();
        chk("sub_wrap_alu", {4'h0, alu_out}, 8'h0E);
        expect_after("sub_wrap", 4'h2, 4'h3, 4'hE);
        tick();
        expect_after("b_ldiC", 4'h3, 4'hC, 4'hE);
        tick();
        expect_after("b_xor", 4'h4, 4'hC, 4'h2);
        tick();
        expect_after("b_ldiF", 4'h5, 4'hF, 4'h2);
        tick();
        chk("add_wrap_alu", {4'h0, alu_out}, 8'h01);
        expect_after("add_wrap", 4'h6, 4'hF, 4'h1);
        tick();

        for (int a = 6; a < 15; a++) begin
            chk("unk_dec",     {3'h0, decoded}, 8'h00);
            chk("unk_restart", {7'h0, restart}, 8'h00);
            expect_after("unk", 4'(a + 1), 4'hF, 4'h1);
            tick();
        end
        expect_after("wrap15", 4'h0, 4'hF, 4'h1);
        tick();

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("async_pc",  {4'h0, pc},      8'h00);
        chk("async_acc", {4'h0, acc_out}, 8'h00);
        chk("async_reg", {4'h0, reg_out}, 8'h00);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // All-NOP ROM: pc counts and wraps, data state stays zero
        for (int k = 0; k < 20; k++) begin
            expect_after("nop_run", 4'((k + 1) % 16), 4'h0, 4'h0);
            tick();
        end

        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
